// File: rtl/gp01_acc_sched.sv
// Frame scheduler for the gp01 select-and-accumulate datapath: merges two
// valid/ready requesters, counts a frame of beats, captures sum and overflow.
module gp01_acc_sched #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_req1_valid,
    input  logic [2:0]       i_req1_data,
    output logic             o_req1_ready,
    input  logic             i_req2_valid,
    input  logic [2:0]       i_req2_data,
    output logic             o_req2_ready,
    output logic [2:0]       o_acc_data1,
    output logic [2:0]       o_acc_data2,
    output logic [1:0]       o_acc_sel,
    output logic             o_acc_rst_n,
    input  logic [5:0]       i_acc_data,
    input  logic             i_acc_ovf,
    output logic             o_busy,
    output logic             o_done,
    output logic [5:0]       o_result,
    output logic             o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_OP2  = 2'b00;
    localparam logic [1:0] SEL_SUM  = 2'b01;
    localparam logic [1:0] SEL_OP1  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic             done_q, done_d;
    logic [5:0]       result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             beat;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            len_q        <= '0;
            ovf_sticky_q <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            ovf_sticky_q <= ovf_sticky_d;
            done_q       <= done_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
        end
    end

    assign beat = i_req1_valid | i_req2_valid;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        len_d        = len_q;
        ovf_sticky_d = ovf_sticky_q;
        done_d       = 1'b0;
        result_d     = result_q;
        ovf_d        = ovf_q;
        o_req1_ready = 1'b0;
        o_req2_ready = 1'b0;
        o_acc_sel    = SEL_ZERO;
        o_acc_rst_n  = 1'b1;

        case (state_q)
            S_IDLE: begin
                // Holding the accumulator cleared here is what isolates frames.
                o_acc_rst_n = 1'b0;
                if (i_start && (i_len != '0)) begin
                    state_d      = S_ACCUM;
                    len_d        = i_len;
                    beat_cnt_d   = '0;
                    ovf_sticky_d = 1'b0;
                end
            end
            S_ACCUM: begin
                o_req1_ready = 1'b1;
                o_req2_ready = 1'b1;
                if (i_acc_ovf) ovf_sticky_d = 1'b1;
                case ({i_req1_valid, i_req2_valid})
                    2'b11:   o_acc_sel = SEL_SUM;
                    2'b10:   o_acc_sel = SEL_OP1;
                    2'b01:   o_acc_sel = SEL_OP2;
                    default: o_acc_sel = SEL_ZERO;
                endcase
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (beat_cnt_q == len_q - LEN_W'(1)) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The last beat's sum and carry are visible from the datapath now.
                if (i_acc_ovf) ovf_sticky_d = 1'b1;
                result_d = i_acc_data;
                ovf_d    = ovf_sticky_q | i_acc_ovf;
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_acc_data1 = (o_req1_ready && i_req1_valid) ? i_req1_data : 3'd0;
    assign o_acc_data2 = (o_req2_ready && i_req2_valid) ? i_req2_data : 3'd0;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_result    = result_q;
    assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_gp01_acc_sched.sv
// Bench for gp01_acc_sched: behavioural accumulator datapath plus a frame-level
// reference model (running sum mod 64, any-carry flag) driving directed and random frames.
module tb_gp01_acc_sched;

    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             i_rst_n;
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_req1_valid, i_req2_valid;
    logic [2:0]       i_req1_data, i_req2_data;
    logic             o_req1_ready, o_req2_ready;
    logic [2:0]       o_acc_data1, o_acc_data2;
    logic [1:0]       o_acc_sel;
    logic             o_acc_rst_n;
    logic [5:0]       i_acc_data;
    logic             i_acc_ovf;
    logic             o_busy, o_done, o_ovf;
    logic [5:0]       o_result;

    int nchk = 0;
    int nfail = 0;

    int tv1[64];
    int td1[64];
    int tv2[64];
    int td2[64];

    gp01_acc_sched #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_req1_valid (i_req1_valid),
        .i_req1_data  (i_req1_data),
        .o_req1_ready (o_req1_ready),
        .i_req2_valid (i_req2_valid),
        .i_req2_data  (i_req2_data),
        .o_req2_ready (o_req2_ready),
        .o_acc_data1  (o_acc_data1),
        .o_acc_data2  (o_acc_data2),
        .o_acc_sel    (o_acc_sel),
        .o_acc_rst_n  (o_acc_rst_n),
        .i_acc_data   (i_acc_data),
        .i_acc_ovf    (i_acc_ovf),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_ovf        (o_ovf)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: select-and-add with wrapping 6-bit sum, per-add carry.
    logic [5:0] dp_sum = 6'd0;
    logic       dp_ovf = 1'b0;
    logic [3:0] dp_in;
    logic [6:0] dp_next;

    always_comb begin
        case (o_acc_sel)
            2'b00:   dp_in = {1'b0, o_acc_data2};
            2'b01:   dp_in = {1'b0, o_acc_data1} + {1'b0, o_acc_data2};
            2'b10:   dp_in = {1'b0, o_acc_data1};
            default: dp_in = 4'd0;
        endcase
    end
    assign dp_next = {1'b0, dp_sum} + {3'b000, dp_in};

    always @(posedge clk) begin
        if (!o_acc_rst_n) begin
            dp_sum <= 6'd0;
            dp_ovf <= 1'b0;
        end else begin
            dp_sum <= dp_next[5:0];
            dp_ovf <= dp_next[6];
        end
    end

    assign i_acc_data = dp_sum;
    assign i_acc_ovf  = dp_ovf;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_sel(input bit v1, input bit v2);
        if (v1 && v2) return 2'b01;
        if (v1)       return 2'b10;
        if (v2)       return 2'b00;
        return 2'b11;
    endfunction

    task automatic set_cyc(input int c, input int v1, input int d1, input int v2, input int d2);
        tv1[c] = v1; td1[c] = d1; tv2[c] = v2; td2[c] = d2;
    endtask

    task automatic clr_tab();
        for (int k = 0; k < 64; k++) set_cyc(k, 0, 0, 0, 0);
    endtask

    // One frame from the IDLE cycle where start is raised through the IDLE after DONE.
    task automatic run_frame(input int len, input bit rnd);
        int beats;
        int cyc;
        int es;
        bit eo;
        int add;
        bit v1, v2;
        int d1, d2;
        beats = 0; cyc = 0; es = 0; eo = 1'b0;

        i_start = 1'b1; i_len = LEN_W'(len);
        i_req1_valid = 1'b1; i_req1_data = 3'd5;
        i_req2_valid = 1'b1; i_req2_data = 3'd6;
        #1;
        chk("idle_acc_rst_n", 8'(o_acc_rst_n), 8'd0);
        chk("idle_ready1", 8'(o_req1_ready), 8'd0);
        chk("idle_data1", 8'(o_acc_data1), 8'd0);
        chk("idle_sel", 8'(o_acc_sel), 8'd3);
        chk("idle_busy", 8'(o_busy), 8'd0);
        tick();
        i_start = 1'b0;

        while (beats < len && cyc < 200) begin
            if (rnd) begin
                v1 = ($urandom_range(0, 2) != 0);
                v2 = ($urandom_range(0, 2) != 0);
                d1 = $urandom_range(0, 7);
                d2 = $urandom_range(0, 7);
                i_start = 1'($urandom_range(0, 1));
                i_len = LEN_W'($urandom_range(0, 15));
            end else begin
                v1 = (cyc < 64) ? (tv1[cyc] != 0) : 1'b0;
                v2 = (cyc < 64) ? (tv2[cyc] != 0) : 1'b0;
                d1 = (cyc < 64) ? td1[cyc] : 0;
                d2 = (cyc < 64) ? td2[cyc] : 0;
            end
            i_req1_valid = v1; i_req1_data = 3'(d1);
            i_req2_valid = v2; i_req2_data = 3'(d2);
            #1;
            chk("accum_busy", 8'(o_busy), 8'd1);
            chk("accum_acc_rst_n", 8'(o_acc_rst_n), 8'd1);
            chk("accum_ready1", 8'(o_req1_ready), 8'd1);
            chk("accum_ready2", 8'(o_req2_ready), 8'd1);
            chk("accum_sel", 8'(o_acc_sel), 8'(exp_sel(v1, v2)));
            chk("accum_data1", 8'(o_acc_data1), v1 ? 8'(d1) : 8'd0);
            chk("accum_data2", 8'(o_acc_data2), v2 ? 8'(d2) : 8'd0);
            chk("accum_done", 8'(o_done), 8'd0);
            if (v1 || v2) begin
                beats++;
                add = (v1 ? d1 : 0) + (v2 ? d2 : 0);
                if (es + add > 63) eo = 1'b1;
                es = (es + add) % 64;
            end
            tick();
            cyc++;
        end
        if (beats < len) chk("frame_timeout", 8'(beats), 8'(len));

        i_start = 1'b0;
        i_req1_valid = 1'b0; i_req2_valid = 1'b0;
        #1;
        chk("wait_busy", 8'(o_busy), 8'd1);
        chk("wait_ready1", 8'(o_req1_ready), 8'd0);
        chk("wait_sel", 8'(o_acc_sel), 8'd3);
        chk("wait_done", 8'(o_done), 8'd0);
        tick();
        chk("done_pulse", 8'(o_done), 8'd1);
        chk("done_result", 8'(o_result), 8'(es));
        chk("done_ovf", 8'(o_ovf), 8'(eo));
        chk("done_ready2", 8'(o_req2_ready), 8'd0);
        tick();
        chk("post_done", 8'(o_done), 8'd0);
        chk("post_busy", 8'(o_busy), 8'd0);
        chk("post_result_held", 8'(o_result), 8'(es));
        chk("post_ovf_held", 8'(o_ovf), 8'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_len = '0;
        i_req1_valid = 1'b0; i_req1_data = 3'd0;
        i_req2_valid = 1'b0; i_req2_data = 3'd0;
        tick(); tick();
        i_rst_n = 1'b1;
        #1;
        chk("rst_acc_rst_n", 8'(o_acc_rst_n), 8'd0);
        chk("rst_sel", 8'(o_acc_sel), 8'd3);
        chk("rst_ready1", 8'(o_req1_ready), 8'd0);
        chk("rst_ready2", 8'(o_req2_ready), 8'd0);
        chk("rst_done", 8'(o_done), 8'd0);
        chk("rst_result", 8'(o_result), 8'd0);
        chk("rst_ovf", 8'(o_ovf), 8'd0);
        chk("rst_busy", 8'(o_busy), 8'd0);

        // Zero-length start is ignored.
        i_start = 1'b1; i_len = '0;
        tick();
        chk("len0_busy", 8'(o_busy), 8'd0);
        i_start = 1'b0;
        tick();

        // req1 only: 1,2,3.
        clr_tab();
        set_cyc(0, 1, 1, 0, 0); set_cyc(1, 1, 2, 0, 0); set_cyc(2, 1, 3, 0, 0);
        run_frame(3, 1'b0);
        chk("req1_only_result", 8'(o_result), 8'd6);

        // Both valid 7,7 twice, then five times (wraps to 6 with carry).
        clr_tab();
        for (int k = 0; k < 8; k++) set_cyc(k, 1, 7, 1, 7);
        run_frame(2, 1'b0);
        chk("both_len2_result", 8'(o_result), 8'd28);
        run_frame(5, 1'b0);
        chk("both_len5_result", 8'(o_result), 8'd6);
        chk("both_len5_ovf", 8'(o_ovf), 8'd1);

        // Gapped req2 beats on cycles 0,2,5.
        clr_tab();
        set_cyc(0, 0, 0, 1, 4); set_cyc(2, 0, 0, 1, 5); set_cyc(5, 0, 0, 1, 6);
        run_frame(3, 1'b0);
        chk("gap_result", 8'(o_result), 8'd15);

        // No carry after a carrying frame: sticky cleared at start.
        clr_tab();
        for (int k = 0; k < 8; k++) set_cyc(k, 1, 7, 1, 7);
        run_frame(3, 1'b0);
        chk("nocarry_result", 8'(o_result), 8'd42);
        chk("nocarry_ovf", 8'(o_ovf), 8'd0);

        // Carry on beat 5 then a non-carrying add: sticky must hold.
        set_cyc(5, 1, 1, 0, 0);
        run_frame(6, 1'b0);
        chk("sticky_result", 8'(o_result), 8'd7);
        chk("sticky_ovf", 8'(o_ovf), 8'd1);

        // Reset after 2 of 4 beats.
        i_start = 1'b1; i_len = 4'd4;
        tick();
        i_start = 1'b0;
        i_req1_valid = 1'b1; i_req1_data = 3'd3;
        tick(); tick();
        i_req1_valid = 1'b0;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        #1;
        chk("midrst_busy", 8'(o_busy), 8'd0);
        chk("midrst_done", 8'(o_done), 8'd0);
        chk("midrst_result", 8'(o_result), 8'd0);
        chk("midrst_acc_rst_n", 8'(o_acc_rst_n), 8'd0);
        tick();
        chk("midrst_done_later", 8'(o_done), 8'd0);
        clr_tab();
        set_cyc(0, 1, 5, 0, 0);
        run_frame(1, 1'b0);
        chk("after_rst_result", 8'(o_result), 8'd5);

        // Random frames, back to back, with mid-frame start/len noise.
        for (int f = 0; f < 12; f++) run_frame($urandom_range(1, 15), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
